// File: rtl/traffic_phase_scheduler.sv
// Demand-driven round-robin phase scheduler for a four-approach intersection.
// Sequences GREEN -> YELLOW -> ALL_RED with tick-based timing and preemption.
module traffic_phase_scheduler #(
    parameter int CNT_W     = 8,
    parameter int MIN_GREEN = 10,
    parameter int MAX_GREEN = 40,
    parameter int YELLOW_T  = 4,
    parameter int ALL_RED_T = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic [3:0] req,
    input  logic [3:0] cong,
    input  logic       preempt,
    input  logic [1:0] preempt_phase,
    output logic [1:0] phase,
    output logic [1:0] color,
    output logic [3:0] light_code,
    output logic       phase_start,
    output logic [3:0] pending
);

    typedef enum logic [1:0] {
        S_RED    = 2'd0,
        S_GREEN  = 2'd1,
        S_YELLOW = 2'd2
    } state_t;

    localparam logic [CNT_W:0] ONE  = (CNT_W+1)'(1);
    localparam logic [CNT_W:0] MING = (CNT_W+1)'(MIN_GREEN);
    localparam logic [CNT_W:0] MAXG = (CNT_W+1)'(MAX_GREEN);
    localparam logic [CNT_W:0] YEL  = (CNT_W+1)'(YELLOW_T);
    localparam logic [CNT_W:0] ARED = (CNT_W+1)'(ALL_RED_T);

    state_t           state, state_d;
    logic [CNT_W-1:0] timer, timer_d;
    logic [CNT_W:0]   n;
    logic [1:0]       rr, rr_d;
    logic [1:0]       phase_d, pick;
    logic [3:0]       pending_d;
    logic [3:0]       cur_oh, green_oh, new_oh;
    logic             other, held, enter_green;
    logic [1:0]       color_d;
    logic [3:0]       light_d;
    logic             start_d;

    assign n      = {1'b0, timer} + ONE;
    assign cur_oh = 4'b0001 << phase;
    assign other  = |(pending & ~cur_oh);
    assign held   = preempt && (phase == preempt_phase);

    // rr holds the last served approach; search begins just after it
    always_comb begin
        pick = rr + 2'd1;
        for (int k = 4; k >= 1; k--) begin
            if (pending[rr + 2'(k)]) pick = rr + 2'(k);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_RED;
            timer       <= '0;
            rr          <= 2'd3;
            phase       <= 2'd0;
            pending     <= 4'd0;
            color       <= 2'b00;
            light_code  <= 4'd0;
            phase_start <= 1'b0;
        end else begin
            state       <= state_d;
            timer       <= timer_d;
            rr          <= rr_d;
            phase       <= phase_d;
            pending     <= pending_d;
            color       <= color_d;
            light_code  <= light_d;
            phase_start <= start_d;
        end
    end

    always_comb begin
        state_d = state;
        unique case (state)
            S_GREEN: begin
                if (preempt && !held)
                    state_d = S_YELLOW;
                else if (tick && !preempt && other &&
                         (n >= MAXG || (n >= MING && !cong[phase])))
                    state_d = S_YELLOW;
            end
            S_YELLOW: if (tick && n == YEL)  state_d = S_RED;
            S_RED:    if (tick && n == ARED) state_d = S_GREEN;
            default:  state_d = S_RED;
        endcase

        enter_green = (state == S_RED) && (state_d == S_GREEN);
        phase_d     = phase;
        if (enter_green) phase_d = preempt ? preempt_phase : pick;
        rr_d = enter_green ? phase_d : rr;

        if (state_d != state)
            timer_d = '0;
        else if (tick && !(&timer))
            timer_d = n[CNT_W-1:0];
        else
            timer_d = timer;

        // the approach showing green does not re-latch its own demand
        green_oh  = (state == S_GREEN) ? cur_oh : 4'd0;
        new_oh    = enter_green ? (4'b0001 << phase_d) : 4'd0;
        pending_d = (pending | (req & ~green_oh)) & ~new_oh;
    end

    always_comb begin
        color_d = 2'b00;
        light_d = 4'd0;
        start_d = enter_green;
        unique case (state_d)
            S_GREEN: begin
                color_d = 2'b01;
                light_d = {1'b0, phase_d, 1'b1};
            end
            S_YELLOW: begin
                color_d = 2'b10;
                light_d = {1'b0, phase_d, 1'b0} + 4'd2;
            end
            default: begin
                color_d = 2'b00;
                light_d = 4'd0;
            end
        endcase
    end

endmodule

// File: doc/traffic_phase_scheduler.md
# traffic_phase_scheduler

Demand-driven phase scheduler that sequences the intersection's four approaches (NS1, NS2, EW1, EW2) through GREEN → YELLOW → ALL_RED. It latches vehicle requests and selects the next approach round-robin among those with pending demand. It times each interval in ticks, honouring minimum and maximum green, congestion extension and emergency preemption. Its `light_code` output uses the light-signal encoding already used by the intersection lamp drivers, with 0 meaning all-red.

## Interface
Parameters:
- `CNT_W`, 8: width of the interval timer.
- `MIN_GREEN`, 10: minimum green, in ticks.
- `MAX_GREEN`, 40: maximum green while another approach has demand, in ticks.
- `YELLOW_T`, 4: yellow duration, in ticks.
- `ALL_RED_T`, 2: all-red clearance, in ticks.
- Legal ranges: `1 ≤ MIN_GREEN ≤ MAX_GREEN < 2^CNT_W`; `YELLOW_T ≥ 1`; `ALL_RED_T ≥ 1`.

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-high reset
- `tick`  in  1  one-cycle timebase strobe; all timing is counted in ticks
- `req`  in  4  per-approach vehicle presence, level (bit i = approach i: 0 NS1, 1 NS2, 2 EW1, 3 EW2)
- `cong`  in  4  per-approach congestion, level
- `preempt`  in  1  emergency preemption request, level
- `preempt_phase`  in  2  approach to serve during preemption
- `phase`  out  2  active or most recent approach
- `color`  out  2  00 red, 01 green, 10 yellow
- `light_code`  out  4  GREEN: 2·phase+1; YELLOW: 2·phase+2; ALL_RED: 0
- `phase_start`  out  1  one-cycle pulse on entry to GREEN
- `pending`  out  4  latched demand flags

## Operation
- States: ALL_RED, GREEN, YELLOW. All outputs are registered.
- Reset values:
  - state ALL_RED, timer 0, phase 0, color 00, light_code 0, phase_start 0, pending 0.
  - The round-robin pointer resets to 3, so the first search starts at approach 0.
- Demand latching:
  - `pending[i]` sets on any cycle where `req[i]` = 1, unless approach i is currently GREEN.
  - `pending[i]` clears on the clock edge that enters GREEN for approach i.
- "Other demand" means any `pending[j]` = 1 with j ≠ phase.
- Timer behaviour: clears on every state entry. On each tick in the same state, n = timer+1; the timer saturates at 2^CNT_W−1.
- GREEN exits to YELLOW on a tick when other demand exists and either:
  - n ≥ MAX_GREEN, or
  - n ≥ MIN_GREEN and `cong[phase]` = 0.
- With no other demand, GREEN rests indefinitely (rest-in-green).
- YELLOW exits to ALL_RED on the tick where n = YELLOW_T.
- ALL_RED exits to GREEN on the tick where n = ALL_RED_T. The next approach is selected at that edge:
  - If `preempt` = 1: `preempt_phase`.
  - Else: the first pending approach searching phase+1, phase+2, phase+3, phase (mod 4).
  - If none is pending: phase+1 (mod 4).
- Preemption:
  - In GREEN with phase ≠ `preempt_phase`, `preempt` = 1 forces YELLOW on the next clock edge. This does not wait for a tick and ignores MIN_GREEN.
  - In GREEN with phase = `preempt_phase`, GREEN is held regardless of MAX_GREEN and other demand.
  - YELLOW and ALL_RED complete normally during preemption and are never shortened.
  - Preemption does not clear other pending flags.
- Simultaneous events:
  - A `req[i]` on the same edge as GREEN entry for approach i leaves `pending[i]` clear.
  - When `preempt` and a tick-based exit coincide, the result is the same single YELLOW entry.

## Timing
- A state change occurs on the `clk` edge where the exit condition holds, except for the preemption exit, which needs no tick.
- Outputs reflect the new state in the cycle after that edge.
- `phase_start` is high for exactly one cycle, coincident with the first GREEN cycle.
- Demand → pending latency: 1 clock.
- Duration of each interval when tick = every cycle: GREEN ≥ MIN_GREEN cycles, YELLOW exactly YELLOW_T, ALL_RED exactly ALL_RED_T.
- Reset mid-operation: outputs go to their reset values immediately (asynchronously), and pending demand is discarded.

## Test plan
Common bench settings: MIN_GREEN=3, MAX_GREEN=6, YELLOW_T=2, ALL_RED_T=1, tick every cycle unless stated.
- Release reset, no `req` → light_code 0 for 1 cycle, then 1 (NS1 green) held indefinitely with `phase_start` pulsing once.
- During NS1 green, pulse `req[2]` for one cycle, `cong`=0 → GREEN lasts 3 cycles, then light_code 2 for 2 cycles, 0 for 1 cycle, then 5; `pending[2]` clears on the GREEN entry.
- Hold `cong[0]`=1 with `req[1]` pending → NS1 green lasts exactly 6 cycles, then the sequence goes to light_code 3.
- In NS2 green with `pending` = 4'b1001 → next green is EW2 (light_code 7); then NS1 (light_code 1).
- Preemption to EW2 (`preempt_phase`=3):
  - Assert `preempt` in NS1 green on cycle 1 → YELLOW on the next edge, then 2 cycles yellow, 1 cycle all-red, then light_code 7.
  - EW2 green is held beyond 6 cycles while `preempt`=1, even with `req[0]` pending.
- Assert `rst` mid-YELLOW with `pending` = 4'b0110, tick every 3rd cycle → immediate light_code 0, pending 0; after release, the all-red interval completes on the next tick and NS1 green follows.
